// File: rtl/cfg_wb_master_if.sv
// Bundle of the command, response and Wishbone signals of cfg_wb_master.
// The master modport is the initiator's view; the slave modport is the view of
// whatever drives commands, consumes responses and plays the Wishbone slave.
interface cfg_wb_master_if;
  logic         cmd_valid_i;
  logic         cmd_ready_o;
  logic         cmd_load_i;
  logic [31:0]  cmd_addr_i;
  logic [1:0]   cmd_nwords_i;
  logic [127:0] cmd_data_i;

  logic         rsp_valid_o;
  logic         rsp_ready_i;
  logic [127:0] rsp_data_o;
  logic         rsp_err_o;

  logic         wbm_cyc_o;
  logic         wbm_stb_o;
  logic         wbm_we_o;
  logic [3:0]   wbm_sel_o;
  logic [31:0]  wbm_adr_o;
  logic [31:0]  wbm_dat_o;
  logic         wbm_ack_i;
  logic [31:0]  wbm_dat_i;

  modport master (
    input  cmd_valid_i, cmd_load_i, cmd_addr_i, cmd_nwords_i, cmd_data_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_data_o, rsp_err_o,
    input  rsp_ready_i,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport slave (
    output cmd_valid_i, cmd_load_i, cmd_addr_i, cmd_nwords_i, cmd_data_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_data_o, rsp_err_o,
    output rsp_ready_i,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_ack_i, wbm_dat_i
  );
endinterface

// File: rtl/cfg_wb_master.sv
// Wishbone initiator for the cfg register file (ADDR, CTRL, DATA_0..DATA_3).
// One store/load command is expanded into single-beat transfers: each strobe
// is a one-cycle pulse, then the master waits (stb low) for the ack or for a
// timeout. cyc stays high for the whole command until the last ack/timeout.
module cfg_wb_master #(
  parameter logic [31:0] WISHBONE_BASE_ADDR = 32'h3000_0000,
  parameter int          RD_WAIT_CYCLES     = 2,
  parameter int          TIMEOUT_CYCLES     = 16,
  parameter int          TIMEOUT_BW         = 5
) (
  input logic            clk_i,
  input logic            rst_i,
  cfg_wb_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    WR_CTRL = 3'd3,
    RD_WAIT = 3'd4,
    RD_DATA = 3'd5,
    RESP    = 3'd6
  } state_t;

  localparam logic [TIMEOUT_BW-1:0] TMO_LAST = TIMEOUT_BW'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_BW-1:0] RDW_LAST =
    TIMEOUT_BW'((RD_WAIT_CYCLES > 0) ? (RD_WAIT_CYCLES - 1) : 0);

  state_t                state_q, state_d;
  logic                  load_q, load_d;
  logic [31:0]           addr_q, addr_d;
  logic [1:0]            nwords_q, nwords_d;
  logic [127:0]          data_q, data_d;
  logic [1:0]            idx_q, idx_d;
  logic                  pend_q, pend_d;
  logic [TIMEOUT_BW-1:0] tmr_q, tmr_d;
  logic [127:0]          rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;

  logic        xfer_state;
  logic        tx_done;
  logic        stb;
  logic        cyc;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat;

  // State and datapath registers; reset returns to IDLE with everything cleared
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      load_q     <= 1'b0;
      addr_q     <= '0;
      nwords_q   <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      tmr_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_q     <= load_d;
      addr_q     <= addr_d;
      nwords_q   <= nwords_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      tmr_q      <= tmr_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Next-state logic: strobe/wait/timeout handling shared by every transfer
  // state, followed by per-state addressing and sequencing
  always_comb begin
    state_d    = state_q;
    load_d     = load_q;
    addr_d     = addr_q;
    nwords_d   = nwords_q;
    data_d     = data_q;
    idx_d      = idx_q;
    pend_d     = pend_q;
    tmr_d      = tmr_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    stb        = 1'b0;
    we         = 1'b0;
    adr        = '0;
    dat        = '0;
    tx_done    = 1'b0;

    xfer_state = (state_q == WR_ADDR) || (state_q == WR_DATA) ||
                 (state_q == WR_CTRL) || (state_q == RD_DATA);
    cyc        = xfer_state || (state_q == RD_WAIT);

    if (xfer_state) begin
      if (!pend_q) begin
        stb    = 1'b1;
        pend_d = 1'b1;
        tmr_d  = '0;
      end else if (bus.wbm_ack_i) begin
        pend_d  = 1'b0;
        tx_done = 1'b1;
      end else if (tmr_q == TMO_LAST) begin
        pend_d    = 1'b0;
        idx_d     = '0;
        rsp_err_d = 1'b1;
        state_d   = RESP;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          load_d     = bus.cmd_load_i;
          addr_d     = bus.cmd_addr_i;
          nwords_d   = bus.cmd_nwords_i;
          data_d     = bus.cmd_data_i;
          idx_d      = '0;
          pend_d     = 1'b0;
          tmr_d      = '0;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          state_d    = WR_ADDR;
        end
      end
      WR_ADDR: begin
        if (stb) begin
          we  = 1'b1;
          adr = WISHBONE_BASE_ADDR;
          dat = addr_q;
        end
        if (tx_done) begin
          idx_d   = '0;
          state_d = load_q ? WR_CTRL : WR_DATA;
        end
      end
      WR_DATA: begin
        if (stb) begin
          we  = 1'b1;
          adr = WISHBONE_BASE_ADDR + 32'h8 + {28'h0, idx_q, 2'b00};
          dat = data_q[{idx_q, 5'b0} +: 32];
        end
        if (tx_done) begin
          if (idx_q == nwords_q) begin
            idx_d   = '0;
            state_d = WR_CTRL;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      WR_CTRL: begin
        if (stb) begin
          we  = 1'b1;
          adr = WISHBONE_BASE_ADDR + 32'h4;
          dat = {30'h0, load_q, ~load_q};
        end
        if (tx_done) begin
          tmr_d   = '0;
          state_d = load_q ? RD_WAIT : RESP;
        end
      end
      RD_WAIT: begin
        if (tmr_q >= RDW_LAST) begin
          tmr_d   = '0;
          idx_d   = '0;
          state_d = RD_DATA;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      RD_DATA: begin
        if (stb) begin
          adr = WISHBONE_BASE_ADDR + 32'h8 + {28'h0, idx_q, 2'b00};
        end
        if (tx_done) begin
          rsp_data_d[{idx_q, 5'b0} +: 32] = bus.wbm_dat_i;
          if (idx_q == nwords_q) begin
            idx_d   = '0;
            state_d = RESP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.cmd_ready_o = (state_q == IDLE);
  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.rsp_data_o  = rsp_data_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.wbm_cyc_o   = cyc;
  assign bus.wbm_stb_o   = stb;
  assign bus.wbm_we_o    = we;
  assign bus.wbm_sel_o   = stb ? 4'hF : 4'h0;
  assign bus.wbm_adr_o   = adr;
  assign bus.wbm_dat_o   = dat;

endmodule

// File: tb/tb_cfg_wb_master.sv
// Self-checking bench for cfg_wb_master: directed commands against a
// registered-ack Wishbone slave model, with scoreboard queues of expected
// bus transfers and responses checked by independent monitor processes.
module tb_cfg_wb_master;

  localparam logic [31:0] BASE    = 32'h3000_0000;
  localparam logic [31:0] A_ADDR  = BASE;
  localparam logic [31:0] A_CTRL  = BASE + 32'h4;
  localparam logic [31:0] NO_ADR  = 32'hFFFF_FFFF;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_exp_t;

  typedef struct packed {
    logic [127:0] data;
    logic         err;
  } rsp_exp_t;

  logic clk;
  logic rst;
  cfg_wb_master_if bus();

  cfg_wb_master dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  wb_exp_t  wb_q[$];
  rsp_exp_t rsp_q[$];

  // slave model state
  logic        ack_q;
  logic [31:0] rdat_q;
  logic        pend_s;
  logic        spur_en;
  logic [31:0] noack_adr;
  logic [31:0] rd_word [4];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("[TB] FAIL %s: wait bound expired (cycle %0d)", name, cyc_n);
  endtask

  // Registered-ack slave; can withhold the ack for one address and can inject
  // a spurious ack into a gap where no transfer is outstanding
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q  <= 1'b0;
      rdat_q <= '0;
      pend_s <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      rdat_q <= '0;
      if (bus.wbm_stb_o) begin
        pend_s <= 1'b1;
        if (bus.wbm_adr_o != noack_adr) begin
          ack_q <= 1'b1;
          if (!bus.wbm_we_o) rdat_q <= rd_word[bus.wbm_adr_o[3:2] - 2'd2];
        end
      end else if (ack_q) begin
        pend_s <= 1'b0;
      end else if (spur_en && bus.wbm_cyc_o && !pend_s) begin
        ack_q <= 1'b1;
      end
    end
  end

  assign bus.wbm_ack_i = ack_q;
  assign bus.wbm_dat_i = rdat_q;

  // Bus monitor: every strobe is compared against the next expected transfer
  logic        prev_stb = 1'b0;
  logic        last_ctrl = 1'b0;
  int          ctrl_ack_cyc = 0;
  always @(negedge clk) begin
    wb_exp_t e;
    if (bus.wbm_ack_i) begin
      if (last_ctrl) ctrl_ack_cyc = cyc_n;
      last_ctrl = 1'b0;
    end
    if (bus.wbm_stb_o) begin
      check("stb one-cycle pulse", {127'h0, prev_stb}, 128'h0);
      if (wb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL unexpected stb: adr %0h we %0b dat %0h", bus.wbm_adr_o, bus.wbm_we_o, bus.wbm_dat_o);
      end else begin
        e = wb_q.pop_front();
        check("wb adr", {96'h0, bus.wbm_adr_o}, {96'h0, e.adr});
        check("wb we",  {127'h0, bus.wbm_we_o}, {127'h0, e.we});
        check("wb dat", {96'h0, bus.wbm_dat_o}, {96'h0, e.dat});
        check("wb sel", {124'h0, bus.wbm_sel_o}, {124'h0, 4'hF});
        check("wb cyc", {127'h0, bus.wbm_cyc_o}, 128'h1);
      end
      if (!bus.wbm_we_o && bus.wbm_adr_o == BASE + 32'h8)
        check("ctrl ack to first read stb", 128'(cyc_n - ctrl_ack_cyc), 128'd3);
      last_ctrl = (bus.wbm_adr_o == A_CTRL);
    end
    prev_stb = bus.wbm_stb_o;
  end

  // Response monitor: each response handshake is compared in order
  always @(negedge clk) begin
    rsp_exp_t r;
    if (bus.rsp_valid_o && bus.rsp_ready_i) begin
      if (rsp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL unexpected rsp: data %0h err %0b", bus.rsp_data_o, bus.rsp_err_o);
      end else begin
        r = rsp_q.pop_front();
        check("rsp data", bus.rsp_data_o, r.data);
        check("rsp err", {127'h0, bus.rsp_err_o}, {127'h0, r.err});
      end
    end
  end

  // Expected write sequence of a store; 'upto' limits it to the first words
  // that actually get a strobe (timeout case), ctrl=0 drops the CTRL write
  task automatic exp_store(input logic [31:0] a, input int n, input logic [127:0] d,
                           input int upto, input bit ctrl);
    wb_q.push_back('{1'b1, A_ADDR, a});
    for (int k = 0; k <= n && k <= upto; k++)
      wb_q.push_back('{1'b1, BASE + 32'h8 + 32'(4 * k), d[32*k +: 32]});
    if (ctrl) wb_q.push_back('{1'b1, A_CTRL, 32'h1});
  endtask

  task automatic exp_load(input logic [31:0] a, input int n, input int upto);
    wb_q.push_back('{1'b1, A_ADDR, a});
    wb_q.push_back('{1'b1, A_CTRL, 32'h2});
    for (int k = 0; k <= n && k <= upto; k++)
      wb_q.push_back('{1'b0, BASE + 32'h8 + 32'(4 * k), 32'h0});
  endtask

  task automatic applyStimulus(input logic ld, input logic [31:0] a, input logic [1:0] n,
                               input logic [127:0] d, output int acc);
    @(posedge clk); #1;
    bus.cmd_load_i   = ld;
    bus.cmd_addr_i   = a;
    bus.cmd_nwords_i = n;
    bus.cmd_data_i   = d;
    bus.cmd_valid_i  = 1'b1;
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.cmd_ready_o) begin
        acc = cyc_n;
        break;
      end
    end
    if (acc < 0) timeout_fail("cmd accept");
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(output int c);
    c = -1;
    for (int i = 0; i < 200; i++) begin
      if (bus.rsp_valid_o) begin
        c = cyc_n;
        break;
      end
      @(negedge clk);
    end
    if (c < 0) timeout_fail("rsp_valid");
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.cmd_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("return to idle");
  endtask

  task automatic wait_stb_adr(input logic [31:0] a);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.wbm_stb_o && bus.wbm_adr_o == a) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("stb at address");
  endtask

  task automatic checkOutput(input string tag);
    check({tag, " cmd_ready"}, {127'h0, bus.cmd_ready_o}, 128'h1);
    check({tag, " cyc"},       {127'h0, bus.wbm_cyc_o}, 128'h0);
    check({tag, " stb"},       {127'h0, bus.wbm_stb_o}, 128'h0);
    check({tag, " we"},        {127'h0, bus.wbm_we_o}, 128'h0);
    check({tag, " adr"},       {96'h0, bus.wbm_adr_o}, 128'h0);
    check({tag, " rsp_valid"}, {127'h0, bus.rsp_valid_o}, 128'h0);
    check({tag, " rsp_data"},  bus.rsp_data_o, 128'h0);
    check({tag, " rsp_err"},   {127'h0, bus.rsp_err_o}, 128'h0);
  endtask

  initial begin
    int acc, rc, cnt;
    logic [127:0] sd;
    rst = 1'b1;
    bus.cmd_valid_i = 1'b0; bus.cmd_load_i = 1'b0; bus.cmd_addr_i = '0;
    bus.cmd_nwords_i = '0;  bus.cmd_data_i = '0;   bus.rsp_ready_i = 1'b1;
    spur_en = 1'b0; noack_adr = NO_ADR;
    rd_word[0] = 32'hDEADBEEF; rd_word[1] = 32'h0BADF00D;
    rd_word[2] = 32'hC0FFEE00; rd_word[3] = 32'h12345678;
    repeat (3) @(negedge clk);
    checkOutput("reset");
    @(posedge clk); #1 rst = 1'b0;

    // store of four words: six writes in order, clean response
    $display("[TB] store nwords=3");
    sd = {32'h44, 32'h33, 32'h22, 32'h11};
    exp_store(32'h010, 3, sd, 3, 1'b1);
    rsp_q.push_back('{128'h0, 1'b0});
    applyStimulus(1'b0, 32'h010, 2'd3, sd, acc);
    wait_rsp(rc);
    wait_idle();

    // store timing with one word: response seven cycles after accept
    $display("[TB] store timing nwords=0");
    exp_store(32'h0AB, 0, 128'h5A5A, 0, 1'b1);
    rsp_q.push_back('{128'h0, 1'b0});
    applyStimulus(1'b0, 32'h0AB, 2'd0, 128'h5A5A, acc);
    wait_rsp(rc);
    check("store accept-to-rsp", 128'(rc - acc), 128'd7);
    wait_idle();

    // load of one word: read returns DATA_0 from the slave
    $display("[TB] load nwords=0");
    exp_load(32'h300, 0, 0);
    rsp_q.push_back('{{96'h0, 32'hDEADBEEF}, 1'b0});
    applyStimulus(1'b1, 32'h300, 2'd0, 128'h0, acc);
    wait_rsp(rc);
    check("load accept-to-rsp", 128'(rc - acc), 128'd9);
    wait_idle();

    // spurious ack injected in the read wait gap must be ignored
    $display("[TB] spurious ack load nwords=1");
    spur_en = 1'b1;
    exp_load(32'h123, 1, 1);
    rsp_q.push_back('{{64'h0, 32'h0BADF00D, 32'hDEADBEEF}, 1'b0});
    applyStimulus(1'b1, 32'h123, 2'd1, 128'h0, acc);
    wait_rsp(rc);
    check("spurious accept-to-rsp", 128'(rc - acc), 128'd11);
    wait_idle();
    spur_en = 1'b0;

    // DATA_1 write never acked: cyc held 16 cycles, no CTRL, err set
    $display("[TB] timeout on DATA_1 write");
    noack_adr = BASE + 32'hC;
    sd = {32'hD4, 32'hC3, 32'hB2, 32'hA1};
    exp_store(32'h777, 3, sd, 1, 1'b0);
    rsp_q.push_back('{128'h0, 1'b1});
    applyStimulus(1'b0, 32'h777, 2'd3, sd, acc);
    wait_stb_adr(BASE + 32'hC);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.wbm_cyc_o) break;
      cnt++;
    end
    check("cyc cycles after unacked stb", 128'(cnt), 128'd16);
    wait_rsp(rc);
    wait_idle();

    // read timeout on DATA_2 keeps the two words already read
    $display("[TB] timeout on DATA_2 read");
    noack_adr = BASE + 32'h10;
    exp_load(32'h888, 3, 2);
    rsp_q.push_back('{{64'h0, 32'h0BADF00D, 32'hDEADBEEF}, 1'b1});
    applyStimulus(1'b1, 32'h888, 2'd3, 128'h0, acc);
    wait_rsp(rc);
    wait_idle();
    noack_adr = NO_ADR;

    // backpressure: response held stable, next command waits for handshake
    $display("[TB] response backpressure");
    @(posedge clk); #1 bus.rsp_ready_i = 1'b0;
    exp_load(32'h040, 2, 2);
    rsp_q.push_back('{{32'h0, 32'hC0FFEE00, 32'h0BADF00D, 32'hDEADBEEF}, 1'b0});
    applyStimulus(1'b1, 32'h040, 2'd2, 128'h0, acc);
    wait_rsp(rc);
    @(posedge clk); #1;
    exp_store(32'h099, 0, 128'h77, 0, 1'b1);
    rsp_q.push_back('{128'h0, 1'b0});
    bus.cmd_load_i = 1'b0; bus.cmd_addr_i = 32'h099; bus.cmd_nwords_i = 2'd0;
    bus.cmd_data_i = 128'h77; bus.cmd_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp rsp_valid", {127'h0, bus.rsp_valid_o}, 128'h1);
      check("bp rsp_data", bus.rsp_data_o, {32'h0, 32'hC0FFEE00, 32'h0BADF00D, 32'hDEADBEEF});
      check("bp cmd_ready", {127'h0, bus.cmd_ready_o}, 128'h0);
    end
    @(posedge clk); #1 bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    check("handshake cycle cmd_ready", {127'h0, bus.cmd_ready_o}, 128'h0);
    @(negedge clk);
    check("post-handshake cmd_ready", {127'h0, bus.cmd_ready_o}, 128'h1);
    check("post-handshake rsp_valid", {127'h0, bus.rsp_valid_o}, 128'h0);
    @(posedge clk); #1 bus.cmd_valid_i = 1'b0;
    wait_rsp(rc);
    wait_idle();

    // reset in the middle of WR_DATA aborts with no response
    $display("[TB] reset mid WR_DATA");
    sd = {32'h4, 32'h3, 32'h2, 32'h1};
    exp_store(32'h0EE, 3, sd, 3, 1'b1);
    rsp_q.push_back('{128'h0, 1'b0});
    applyStimulus(1'b0, 32'h0EE, 2'd3, sd, acc);
    wait_stb_adr(BASE + 32'hC);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    checkOutput("mid-reset");
    wb_q.delete();
    rsp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    exp_store(32'h055, 0, 128'h99, 0, 1'b1);
    rsp_q.push_back('{128'h0, 1'b0});
    applyStimulus(1'b0, 32'h055, 2'd0, 128'h99, acc);
    wait_rsp(rc);
    check("after-reset accept-to-rsp", 128'(rc - acc), 128'd7);
    wait_idle();

    repeat (3) @(negedge clk);
    check("wb expectations drained", 128'(wb_q.size()), 128'd0);
    check("rsp expectations drained", 128'(rsp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global timeout reached");
    $fatal(1, "[TB] global timeout");
  end

endmodule
